ch446_serial_tx: RTL and testbench
==================================

Name: ch446_serial_tx

Overview:
- Transmitter end of the CH446Q-style serial keyboard-matrix link, on the HIDman controller side.
- Accepts key-switch commands (7-bit address plus DAT level) through a valid/ready port and queues them in a small FIFO.
- Replays each command as DAT/SK/STB waveforms that the ZX-bus keyboard receiver consumes.
- Also generates an autonomous "release all" sweep, used on host hot-unplug or keyboard reset.

Parameters:
- CLK_DIV, 4, clk cycles per SK half-period; also the length of the setup, STB-high and hold phases; must be >= 1.
- FIFO_DEPTH, 8, command FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on a rising clk edge
- cmd_addr  in  7  {AY[2:0], AX[3:0]}; AX=8 selects the special lines (Y5 MAGIC, Y6 RESET, Y7 PAUSE)
- cmd_dat  in  1  DAT level sent at strobe; 1 = key released / special deasserted, 0 = pressed / asserted
- release_all  in  1  single-cycle request to release every key and special line
- DAT  out  1  serial data to receiver
- SK  out  1  serial clock; receiver shifts on its rising edge
- STB  out  1  strobe; receiver latches on its rising edge
- busy  out  1  FSM not IDLE, FIFO non-empty, or sweep pending
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset values (first edge with rst=1, including mid-frame): DAT=1, SK=0, STB=0, FIFO emptied, sweep cancelled, FSM=IDLE, busy=0, fifo_count=0. cmd_ready=0 while rst=1.
- cmd_ready = ~rst & ~full & ~sweep_active & ~release_all. If cmd_valid and release_all occur in the same cycle, the command is not accepted.
- FIFO is first-word-fall-through. A simultaneous push and pop is allowed when full, but cmd_ready is still 0 when full, so no push occurs that cycle.
- FSM states: IDLE -> SHIFT_LO -> SHIFT_HI (x7 bits) -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE: if a sweep is active, load the next sweep command. Otherwise, if the FIFO is non-empty, pop the head. Either load goes to SHIFT_LO with bit index 6.
- SHIFT_LO: DAT = addr[idx], SK=0, for CLK_DIV cycles.
- SHIFT_HI: SK=1 (rising edge at phase entry) for CLK_DIV cycles, DAT held. Then decrement idx; go to SHIFT_LO if idx > 0, else to SETUP. Bit order is MSB first (AY2 ... AX0).
- SETUP: SK=0, DAT = cmd_dat, for CLK_DIV cycles.
- STROBE: STB=1 for CLK_DIV cycles, DAT held.
- HOLD: STB=0, DAT held, for CLK_DIV cycles. Then go to IDLE; DAT remains at the last value until the next load.
- Frame length is exactly 17*CLK_DIV cycles from leaving IDLE to returning to IDLE. Back-to-back frames insert 1 IDLE cycle.
- SK and STB are never high simultaneously. DAT changes only while SK=0 and STB=0.
- release_all sets a pending flag and flushes the FIFO on the same edge. A frame already in progress completes unmodified.
- Sweep then sends 43 frames, all with DAT=1, in this order:
  - matrix: AY 0..4 outer, AX 0..7 inner (addr = {AY, 1'b0, AX[2:0]}), 40 frames;
  - specials: addr 7'h58, 7'h68, 7'h78.
- sweep_active stays set until the 43rd frame's HOLD ends. A release_all during a sweep restarts the sweep at index 0 after the current frame.
- Sweep counter is 6 bits and never wraps past 42.

Test Plan:
- Reset then push addr=7'h24, dat=0 with CLK_DIV=4 -> SK rising edges at cycles 5,13,...,53 after load, sampled DAT bits 0,1,0,0,1,0,0; STB high cycles 61-64 with DAT=0; back to IDLE at cycle 68; busy drops.
- Push 9 commands back-to-back with FIFO_DEPTH=8 -> cmd_ready low once 8 are queued, rises after the first pop; all 9 frames emitted in order, 1 IDLE cycle between frames.
- Model the receiver (7-bit shift on SK, latch on STB) -> after pushing addr 7'h13 dat 0, row A9 / D1 reads 0; after addr 7'h68 dat 0, the RESET line is asserted.
- Queue 5 commands, then pulse release_all mid-frame of the first -> first frame completes, remaining 4 are discarded, 43 frames follow with DAT=1 at strobe, last addr 7'h78; cmd_ready stays low throughout.
- Assert rst during STROBE -> next edge STB=0, SK=0, DAT=1, fifo_count=0; a fresh command after reset produces a complete, correct frame.
- Same-cycle cmd_valid and release_all -> command not accepted (fifo_count unchanged), sweep runs.

Source files
------------

// File: rtl/ch446_serial_tx.sv
// CH446Q-style serial transmitter: queued key-switch commands are shifted MSB-first on DAT/SK
// and latched with STB; release_all replaces the queue with a 43-frame "release everything" sweep.
module ch446_serial_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [6:0]                  cmd_addr,
  input  logic                        cmd_dat,
  input  logic                        release_all,
  output logic                        DAT,
  output logic                        SK,
  output logic                        STB,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0]    SWEEP_LAST = 6'd42;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SETUP    = 3'd3,
    S_STROBE   = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  // Sweep order: 40 matrix keys (AY 0..4, AX 0..7), then the AX=8 specials on Y5, Y6, Y7.
  function automatic logic [6:0] sweep_addr(input logic [5:0] idx);
    logic [2:0] ay_s;
    ay_s = idx[2:0] + 3'd5;
    if (idx < 6'd40) begin
      sweep_addr = {idx[5:3], 1'b0, idx[2:0]};
    end else begin
      sweep_addr = {ay_s, 4'h8};
    end
  endfunction

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]    idx_r, idx_nxt_s;
  logic [6:0]    frame_addr_r;
  logic          frame_dat_r;
  logic          dat_r, sk_r, stb_r, dat_nxt_s;
  logic          load_s, hold_end_s, phase_done_s;
  logic [6:0]    load_addr_s;
  logic          load_dat_s;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r, count_s;
  logic          full_s, empty_s, push_s, pop_s;
  logic [7:0]    head_s;

  logic          sweep_active_r, sweep_last_r;
  logic [5:0]    sweep_idx_r;

  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign full_s       = (count_s == DEPTH_C);
  assign empty_s      = (count_s == {(AW+1){1'b0}});
  assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
  assign cmd_ready    = ~rst & ~full_s & ~sweep_active_r & ~release_all;
  assign push_s       = cmd_valid & cmd_ready;
  assign pop_s        = load_s & ~sweep_active_r;
  assign phase_done_s = (cnt_r == CNT_LAST);
  assign load_addr_s  = sweep_active_r ? sweep_addr(sweep_idx_r) : head_s[7:1];
  assign load_dat_s   = sweep_active_r ? 1'b1 : head_s[0];

  // Next-state and DAT decode; every phase lasts CLK_DIV cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    dat_nxt_s   = dat_r;
    load_s      = 1'b0;
    hold_end_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        // A release_all cycle never loads: the sweep starts cleanly from index 0 next cycle.
        if (!release_all && (sweep_active_r || !empty_s)) begin
          load_s      = 1'b1;
          state_nxt_s = S_SHIFT_LO;
          cnt_nxt_s   = {CW{1'b0}};
          idx_nxt_s   = 3'd6;
          dat_nxt_s   = load_addr_s[6];
        end else begin
          cnt_nxt_s   = {CW{1'b0}};
        end
      end
      S_SHIFT_LO: begin
        if (phase_done_s) begin
          state_nxt_s = S_SHIFT_HI;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      S_SHIFT_HI: begin
        if (phase_done_s) begin
          cnt_nxt_s = {CW{1'b0}};
          if (idx_r != 3'd0) begin
            state_nxt_s = S_SHIFT_LO;
            idx_nxt_s   = idx_r - 3'd1;
            dat_nxt_s   = frame_addr_r[idx_r - 3'd1];
          end else begin
            state_nxt_s = S_SETUP;
            dat_nxt_s   = frame_dat_r;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      S_SETUP: begin
        if (phase_done_s) begin
          state_nxt_s = S_STROBE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      S_STROBE: begin
        if (phase_done_s) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      S_HOLD: begin
        if (phase_done_s) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
          hold_end_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State register and registered line drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CW{1'b0}};
      idx_r        <= 3'd0;
      frame_addr_r <= 7'h00;
      frame_dat_r  <= 1'b1;
      dat_r        <= 1'b1;
      sk_r         <= 1'b0;
      stb_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      dat_r   <= dat_nxt_s;
      sk_r    <= (state_nxt_s == S_SHIFT_HI);
      stb_r   <= (state_nxt_s == S_STROBE);
      if (load_s) begin
        frame_addr_r <= load_addr_s;
        frame_dat_r  <= load_dat_s;
      end
    end
  end

  // Command storage, {addr, dat} per entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {cmd_addr, cmd_dat};
    end
  end

  // FIFO pointers; release_all discards everything queued.
  always_ff @(posedge clk) begin
    if (rst || release_all) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Sweep sequencer; index saturates at the last special line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_active_r <= 1'b0;
      sweep_idx_r    <= 6'd0;
      sweep_last_r   <= 1'b0;
    end else if (release_all) begin
      sweep_active_r <= 1'b1;
      sweep_idx_r    <= 6'd0;
      sweep_last_r   <= 1'b0;
    end else begin
      if (load_s && sweep_active_r) begin
        sweep_last_r <= (sweep_idx_r == SWEEP_LAST);
        if (sweep_idx_r != SWEEP_LAST) sweep_idx_r <= sweep_idx_r + 6'd1;
      end
      if (hold_end_s && sweep_last_r) begin
        sweep_active_r <= 1'b0;
        sweep_last_r   <= 1'b0;
      end
    end
  end

  assign DAT        = dat_r;
  assign SK         = sk_r;
  assign STB        = stb_r;
  assign busy       = (state_r != S_IDLE) | ~empty_s | sweep_active_r;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_ch446_serial_tx.sv
// Directed bench for ch446_serial_tx: a behavioural CH446Q receiver (shift on SK, latch on STB)
// records every delivered frame; each task checks its scenario against hand-derived values.
module tb_ch446_serial_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 17 * CLK_DIV;
  localparam logic [6:0] B2B_A [9] = '{7'h01, 7'h12, 7'h23, 7'h34, 7'h45, 7'h56, 7'h67, 7'h10, 7'h7f};
  localparam logic [8:0] B2B_D = 9'b1_0110_1001;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_dat, release_all, DAT, SK, STB, busy;
  logic [6:0] cmd_addr;
  logic [3:0] fifo_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int viol_cnt = 0;

  logic [6:0] rx_sh;
  logic       rx_state [128];
  logic [6:0] rx_addr_log [512];
  logic       rx_dat_log [512];
  time        rx_time [512];
  int         rx_cnt;
  logic       rx_clr = 1'b0;
  logic       mon_en = 1'b0;
  logic       prev_dat;

  ch446_serial_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_dat(cmd_dat), .release_all(release_all), .DAT(DAT), .SK(SK), .STB(STB),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge SK) rx_sh <= {rx_sh[5:0], DAT};

  always @(posedge STB or posedge rx_clr) begin
    if (rx_clr) begin
      for (int i = 0; i < 128; i++) rx_state[i] <= 1'b1;
      rx_cnt <= 0;
    end else begin
      rx_state[rx_sh]         <= DAT;
      rx_addr_log[rx_cnt % 512] <= rx_sh;
      rx_dat_log[rx_cnt % 512]  <= DAT;
      rx_time[rx_cnt % 512]     <= $time;
      rx_cnt                  <= rx_cnt + 1;
    end
  end

  // Line-discipline watch: SK/STB exclusive, DAT moves only with both low.
  always @(negedge clk) begin
    if (mon_en && ((SK && STB) || ((DAT !== prev_dat) && (SK || STB)))) viol_cnt <= viol_cnt + 1;
    prev_dat <= DAT;
  end

  task automatic push_cmd(input logic [6:0] a, input logic d);
    int n = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = a; cmd_dat = d;
    while (!cmd_ready && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; release_all = 1'b0; cmd_addr = 7'h00; cmd_dat = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (DAT !== 1'b1) begin err_cnt++; $display("FAIL reset_dat: got %b want 1", DAT); end
    vec_cnt++; if (SK !== 1'b0) begin err_cnt++; $display("FAIL reset_sk: got %b want 0", SK); end
    vec_cnt++; if (STB !== 1'b0) begin err_cnt++; $display("FAIL reset_stb: got %b want 0", STB); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (fifo_count !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    rst = 1'b0;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready); end
    @(negedge clk); mon_en = 1'b1;
  endtask

  task automatic test_frame_timing;
    logic sk_v [72]; logic stb_v [72]; logic dat_v [72]; logic busy_v [72];
    logic [6:0] a; int base, sk_hi, stb_bad, dat_bad;
    a = 7'h24; base = rx_cnt; sk_hi = 0; stb_bad = 0; dat_bad = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = a; cmd_dat = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    vec_cnt++; if (fifo_count !== 4'd1) begin err_cnt++; $display("FAIL timing_queued: got %0d want 1", fifo_count); end
    for (int c = 1; c < 72; c++) begin
      @(negedge clk); sk_v[c] = SK; stb_v[c] = STB; dat_v[c] = DAT; busy_v[c] = busy;
    end
    for (int k = 0; k < 7; k++) begin
      vec_cnt++;
      if (sk_v[4+8*k] !== 1'b0 || sk_v[5+8*k] !== 1'b1) begin
        err_cnt++; $display("FAIL sk_rise_%0d: cycles %0d/%0d got %b%b want 01", k, 4+8*k, 5+8*k, sk_v[4+8*k], sk_v[5+8*k]);
      end
      vec_cnt++;
      if (dat_v[5+8*k] !== a[6-k]) begin err_cnt++; $display("FAIL dat_bit_%0d: got %b want %b", k, dat_v[5+8*k], a[6-k]); end
    end
    for (int c = 1; c < 72; c++) begin
      if (sk_v[c] === 1'b1) sk_hi++;
      if (stb_v[c] !== ((c >= 61 && c <= 64) ? 1'b1 : 1'b0)) stb_bad++;
      if (c >= 61 && c <= 64 && dat_v[c] !== 1'b0) dat_bad++;
    end
    vec_cnt++; if (sk_hi != 28) begin err_cnt++; $display("FAIL sk_high_cycles: got %0d want 28", sk_hi); end
    vec_cnt++; if (stb_bad != 0) begin err_cnt++; $display("FAIL stb_window: got %0d bad cycles want 0", stb_bad); end
    vec_cnt++; if (dat_bad != 0) begin err_cnt++; $display("FAIL dat_at_strobe: got %0d bad cycles want 0", dat_bad); end
    vec_cnt++; if (busy_v[68] !== 1'b1 || busy_v[69] !== 1'b0) begin
      err_cnt++; $display("FAIL frame_end: busy c68/c69 got %b%b want 10", busy_v[68], busy_v[69]);
    end
    vec_cnt++; if (rx_cnt != base + 1 || rx_addr_log[base] !== a || rx_dat_log[base] !== 1'b0) begin
      err_cnt++; $display("FAIL timing_rx: got n=%0d addr=%h dat=%b want n=1 addr=24 dat=0", rx_cnt - base, rx_addr_log[base], rx_dat_log[base]);
    end
  endtask

  task automatic test_back_to_back;
    int base, n, bad_order, bad_gap;
    base = rx_cnt; bad_order = 0; bad_gap = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); cmd_valid = 1'b1; cmd_addr = B2B_A[i]; cmd_dat = B2B_D[i];
      n = 0;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    end
    @(negedge clk); cmd_valid = 1'b0;
    vec_cnt++; if (fifo_count !== 4'd8) begin err_cnt++; $display("FAIL b2b_full_count: got %0d want 8", fifo_count); end
    vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_full_ready: got %b want 0", cmd_ready); end
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    vec_cnt++; if (n != 62 || fifo_count !== 4'd7) begin
      err_cnt++; $display("FAIL b2b_ready_rise: after %0d cycles count=%0d want 62 cycles count=7", n, fifo_count);
    end
    wait_idle(n);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_timeout: busy=%b want 0", busy); end
    vec_cnt++; if (rx_cnt != base + 9) begin err_cnt++; $display("FAIL b2b_frames: got %0d want 9", rx_cnt - base); end
    for (int i = 0; i < 9; i++) begin
      if (rx_addr_log[base+i] !== B2B_A[i] || rx_dat_log[base+i] !== B2B_D[i]) bad_order++;
      if (i > 0 && rx_time[base+i] - rx_time[base+i-1] != (FRAME + 1) * 10) bad_gap++;
    end
    vec_cnt++; if (bad_order != 0) begin err_cnt++; $display("FAIL b2b_order: got %0d wrong frames want 0", bad_order); end
    vec_cnt++; if (bad_gap != 0) begin err_cnt++; $display("FAIL b2b_gap: got %0d wrong spacings want 0", bad_gap); end
  endtask

  task automatic test_receiver;
    int n;
    push_cmd(7'h13, 1'b0); wait_idle(n);
    vec_cnt++; if (rx_state[7'h13] !== 1'b0) begin err_cnt++; $display("FAIL rx_a9_d1: got %b want 0", rx_state[7'h13]); end
    vec_cnt++; if (rx_state[7'h68] !== 1'b1) begin err_cnt++; $display("FAIL rx_reset_idle: got %b want 1", rx_state[7'h68]); end
    push_cmd(7'h68, 1'b0); wait_idle(n);
    vec_cnt++; if (rx_state[7'h68] !== 1'b0) begin err_cnt++; $display("FAIL rx_reset_line: got %b want 0", rx_state[7'h68]); end
  endtask

  task automatic test_release_all;
    int base, n, ready_hi, bad;
    logic [6:0] ea;
    base = rx_cnt; ready_hi = 0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cmd_valid = 1'b1; cmd_addr = 7'h31 + 7'(i); cmd_dat = 1'b0;
    end
    @(negedge clk); cmd_valid = 1'b0;
    vec_cnt++; if (fifo_count !== 4'd4) begin err_cnt++; $display("FAIL rel_queued: got %0d want 4", fifo_count); end
    repeat (20) @(negedge clk);
    release_all = 1'b1;
    @(negedge clk); release_all = 1'b0;
    vec_cnt++; if (fifo_count !== 4'd0 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL rel_flush: count=%0d busy=%b want count=0 busy=1", fifo_count, busy);
    end
    n = 0;
    while (busy && n < 5000) begin
      if (cmd_ready) ready_hi++;
      @(negedge clk); n++;
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rel_timeout: busy=%b want 0", busy); end
    vec_cnt++; if (ready_hi != 0) begin err_cnt++; $display("FAIL rel_ready_low: got %0d ready cycles want 0", ready_hi); end
    vec_cnt++; if (rx_cnt != base + 44) begin err_cnt++; $display("FAIL rel_frames: got %0d want 44", rx_cnt - base); end
    vec_cnt++; if (rx_addr_log[base] !== 7'h31 || rx_dat_log[base] !== 1'b0) begin
      err_cnt++; $display("FAIL rel_first: got addr=%h dat=%b want 31/0", rx_addr_log[base], rx_dat_log[base]);
    end
    for (int j = 0; j < 43; j++) begin
      if (j < 40) ea = 7'((j / 8) * 16 + (j % 8));
      else        ea = 7'(8'h58 + (j - 40) * 16);
      if (rx_addr_log[base+1+j] !== ea || rx_dat_log[base+1+j] !== 1'b1) bad++;
    end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL rel_sweep_seq: got %0d wrong frames want 0", bad); end
    vec_cnt++; if (rx_addr_log[base+43] !== 7'h78) begin err_cnt++; $display("FAIL rel_last: got %h want 78", rx_addr_log[base+43]); end
    vec_cnt++; if (rx_state[7'h13] !== 1'b1 || rx_state[7'h68] !== 1'b1 || rx_state[7'h31] !== 1'b1) begin
      err_cnt++; $display("FAIL rel_released: 13/68/31 got %b%b%b want 111", rx_state[7'h13], rx_state[7'h68], rx_state[7'h31]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base, n;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 7'h55; cmd_dat = 1'b0;
    @(negedge clk); cmd_addr = 7'h66;
    @(negedge clk); cmd_valid = 1'b0;
    n = 0;
    while (STB !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vec_cnt++; if (STB !== 1'b1 || fifo_count !== 4'd1) begin
      err_cnt++; $display("FAIL rst_setup: stb=%b count=%0d want stb=1 count=1", STB, fifo_count);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++; if (STB !== 1'b0 || SK !== 1'b0 || DAT !== 1'b1) begin
      err_cnt++; $display("FAIL rst_lines: stb/sk/dat got %b%b%b want 001", STB, SK, DAT);
    end
    vec_cnt++; if (fifo_count !== 4'd0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rst_state: count=%0d busy=%b want 0/0", fifo_count, busy);
    end
    rst = 1'b0;
    base = rx_cnt;
    push_cmd(7'h2a, 1'b0); wait_idle(n);
    vec_cnt++; if (rx_cnt != base + 1 || rx_addr_log[base] !== 7'h2a || rx_dat_log[base] !== 1'b0) begin
      err_cnt++; $display("FAIL rst_fresh: n=%0d addr=%h dat=%b want 1/2a/0", rx_cnt - base, rx_addr_log[base], rx_dat_log[base]);
    end
  endtask

  task automatic test_same_cycle;
    int base, n, zeros;
    base = rx_cnt; zeros = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 7'h05; cmd_dat = 1'b0; release_all = 1'b1;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL same_ready: got %b want 0", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0; release_all = 1'b0;
    vec_cnt++; if (fifo_count !== 4'd0 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL same_state: count=%0d busy=%b want 0/1", fifo_count, busy);
    end
    wait_idle(n);
    for (int j = 0; j < 43; j++) if (rx_dat_log[base+j] !== 1'b1) zeros++;
    vec_cnt++; if (rx_cnt != base + 43 || rx_addr_log[base] !== 7'h00 || zeros != 0) begin
      err_cnt++; $display("FAIL same_sweep: n=%0d first=%h zeros=%0d want 43/00/0", rx_cnt - base, rx_addr_log[base], zeros);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; release_all = 1'b0; cmd_addr = 7'h00; cmd_dat = 1'b1;
    #1 rx_clr = 1'b1;
    #1 rx_clr = 1'b0;
    test_reset();
    test_frame_timing();
    test_back_to_back();
    test_receiver();
    test_release_all();
    test_reset_mid_frame();
    test_same_cycle();
    @(negedge clk);
    vec_cnt++; if (viol_cnt != 0) begin err_cnt++; $display("FAIL line_discipline: got %0d violations want 0", viol_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
